// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default widths and the step-counter width.
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

  localparam int CW_DEF = cnt_w(DW_DEF);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, then subtract the
// divisor if it fits. Purely combinational.
module div_step #(
  parameter int VW = div_pkg::VW_DEF
) (
  input  logic [VW:0]   r,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  logic [VW:0] t;
  logic [VW:0] dvs_ext;

  assign t       = {r[VW-1:0], bit_in};
  assign dvs_ext = {1'b0, divisor};
  assign q_bit   = (t >= dvs_ext);
  assign r_next  = q_bit ? (t - dvs_ext) : t;

endmodule

// File: rtl/seq_div8x4.sv
// Sequential restoring divider, one quotient bit per clock behind start/busy/done.
// Optional macro DIV_DBZ_EN compiles in zero-divisor detection and short-circuit.
module seq_div8x4
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = cnt_w(DW);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW:0]   r;
  logic [DW-1:0] q_sh;
  logic [VW:0]   r_next;
  logic          q_bit;
  logic          last;
  logic          dbz_hit;

  div_step #(.VW(VW)) u_step (
    .r       (r),
    .bit_in  (dvd[DW-1]),
    .divisor (dvs),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  assign last = (cnt == CW'(DW - 1));

`ifdef DIV_DBZ_EN
  logic dbz_q;
  assign dbz_hit     = (dvs == '0);
  assign div_by_zero = dbz_q;
`else
  assign dbz_hit     = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A zero divisor spends a single CALC cycle so done lands one edge after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (dbz_hit || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      r         <= '0;
      q_sh      <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DIV_DBZ_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvd  <= dividend;
          dvs  <= divisor;
          r    <= '0;
          cnt  <= '0;
          busy <= 1'b1;
        end
        CALC: if (dbz_hit) begin
          quotient  <= '1;
          remainder <= dvd[VW-1:0];
          done      <= 1'b1;
`ifdef DIV_DBZ_EN
          dbz_q     <= 1'b1;
`endif
        end else begin
          r    <= r_next;
          dvd  <= dvd << 1;
          q_sh <= {q_sh[DW-2:0], q_bit};
          cnt  <= cnt + 1'b1;
          if (last) begin
            quotient  <= {q_sh[DW-2:0], q_bit};
            remainder <= r_next[VW-1:0];
            done      <= 1'b1;
`ifdef DIV_DBZ_EN
            dbz_q     <= 1'b0;
`endif
          end
        end
        DONE:    busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div8x4.sv
// Directed bench for seq_div8x4: reset, normal divisions, ignored start,
// mid-operation reset and zero divisor (expectations follow DIV_DBZ_EN).
module tb_seq_div8x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_div8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Pulses start for one rising edge; returns at the negedge after the accept.
  task automatic drive_start(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts cycles after the accept until done is seen (bounded at 20).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; dividend = 8'h08; divisor = 4'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, div_by_zero, quotient, remainder} !== 15'd0) begin
        n_bad++;
        $display("FAIL reset_hold: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                 busy, done, div_by_zero, quotient, remainder);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_busy: got %b want 1", busy);
    end
    begin
      int lat, bcnt;
      wait_done(lat, bcnt);
      n_cmp++;
      if (lat !== 8 || quotient !== 8'h02 || remainder !== 4'h0) begin
        n_bad++;
        $display("FAIL reset_release_result: got lat=%0d q=%h r=%h want lat=8 q=02 r=0",
                 lat, quotient, remainder);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bcnt;
    drive_start(8'h08, 4'h4);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL basic_accept: got busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(lat, bcnt);
    n_cmp++;
    if (lat !== 8) begin
      n_bad++; $display("FAIL basic_latency: got %0d want 8", lat);
    end
    n_cmp++;
    if (quotient !== 8'h02 || remainder !== 4'h0 || div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_result: got q=%h r=%h dbz=%b want q=02 r=0 dbz=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    n_cmp++;
    if (bcnt !== 9 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy: got bcnt=%0d busy=%b done=%b want 9/0/0", bcnt, busy, done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (quotient !== 8'h02 || remainder !== 4'h0) begin
      n_bad++; $display("FAIL basic_hold: got q=%h r=%h want 02/0", quotient, remainder);
    end
  endtask

  task automatic test_patterns;
    logic [7:0] a  [2] = '{8'h46, 8'hC8};
    logic [3:0] b  [2] = '{4'h7,  4'h7};
    logic [7:0] eq [2] = '{8'h0A, 8'h1C};
    logic [3:0] er [2] = '{4'h0,  4'h4};
    for (int i = 0; i < 2; i++) begin
      int lat, bcnt;
      drive_start(a[i], b[i]);
      wait_done(lat, bcnt);
      n_cmp++;
      if (lat !== 8 || quotient !== eq[i] || remainder !== er[i]) begin
        n_bad++;
        $display("FAIL pattern_%0d: got lat=%0d q=%h r=%h want lat=8 q=%h r=%h",
                 i, lat, quotient, remainder, eq[i], er[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcnt, extra;
    drive_start(8'hFF, 4'hF);
    repeat (2) @(negedge clk);
    dividend = 8'h10; divisor = 4'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    n_cmp++;
    if (quotient !== 8'h11 || remainder !== 4'h0) begin
      n_bad++;
      $display("FAIL ignore_start_result: got q=%h r=%h want 11/0", quotient, remainder);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++; $display("FAIL ignore_start_second: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    drive_start(8'hC8, 4'h7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_mid_state: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL reset_mid_no_done: got %0d active cycles want 0", pulses);
    end
  endtask

  task automatic test_dbz;
    int lat, bcnt;
`ifdef DIV_DBZ_EN
    int   exp_lat = 1;
    logic exp_dbz = 1'b1;
`else
    int   exp_lat = 8;
    logic exp_dbz = 1'b0;
`endif
    drive_start(8'h2D, 4'h0);
    wait_done(lat, bcnt);
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++; $display("FAIL dbz_latency: got %0d want %0d", lat, exp_lat);
    end
    n_cmp++;
    if (quotient !== 8'hFF || remainder !== 4'hD || div_by_zero !== exp_dbz) begin
      n_bad++;
      $display("FAIL dbz_result: got q=%h r=%h dbz=%b want q=ff r=d dbz=%b",
               quotient, remainder, div_by_zero, exp_dbz);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== exp_dbz) begin
      n_bad++;
      $display("FAIL dbz_after: got busy=%b done=%b dbz=%b want 0/0/%b",
               busy, done, div_by_zero, exp_dbz);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset;
    test_basic;
    test_patterns;
    test_ignore_start;
    test_reset_mid;
    test_dbz;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
